viterbi_traceback_ctrl: RTL and testbench

VITERBI_TRACEBACK_CTRL -- requirements
Module: viterbi_traceback_ctrl

---
 rtl/viterbi_traceback_ctrl.sv | 168 ++++++++++++++++
 tb/tb_viterbi_traceback_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/viterbi_traceback_ctrl.sv
// Viterbi traceback controller: walks the backpointer memory from the last word
// back to word 0, stacks the decoded tags, then drains them in word order.
module viterbi_traceback_ctrl #(
    parameter int unsigned size_state = 4,
    parameter int unsigned size_word  = 4,
    parameter int unsigned num_tags   = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [size_word-1:0]  num_words,
    input  logic [size_state-1:0] best_last_pos,
    output logic                  bp_rd_en,
    output logic [size_word-1:0]  bp_addr_word,
    output logic [size_state-1:0] bp_addr_pos,
    input  logic [size_state-1:0] bp_data,
    output logic [size_state-1:0] out_pos,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [2:0]            state
);

    localparam int unsigned DEPTH = 2 ** size_word;
    localparam logic [size_state:0] NUM_TAGS_EXT = (size_state + 1)'(num_tags);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PUSH  = 3'd1,
        ST_RD    = 3'd2,
        ST_CAP   = 3'd3,
        ST_DRAIN = 3'd4,
        ST_DONE  = 3'd5,
        ST_ERR   = 3'd6
    } state_t;

    state_t                state_q, state_d;
    logic [size_word-1:0]  sp_q, sp_d;
    logic [size_word-1:0]  w_q, w_d;
    logic [size_state-1:0] tag_q, tag_d;
    logic                  err_d;
    logic                  push;
    logic [size_state-1:0] stack_q [DEPTH];

    logic                  rd_en_d;
    logic [size_word-1:0]  addr_word_d;
    logic [size_state-1:0] addr_pos_d;
    logic                  out_valid_d;
    logic [size_state-1:0] out_pos_d;
    logic [size_state-1:0] top_d;
    logic                  busy_d;
    logic                  done_d;

    assign state = state_q;

    // Next-state logic plus the next values of every registered output.
    always_comb begin
        state_d = state_q;
        sp_d    = sp_q;
        w_d     = w_q;
        tag_d   = tag_q;
        err_d   = error;
        push    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (num_words == '0 || {1'b0, best_last_pos} >= NUM_TAGS_EXT) begin
                        state_d = ST_ERR;
                        err_d   = 1'b1;
                    end else begin
                        tag_d   = best_last_pos;
                        w_d     = num_words - size_word'(1);
                        err_d   = 1'b0;
                        state_d = ST_PUSH;
                    end
                end
            end
            ST_PUSH: begin
                push    = 1'b1;
                sp_d    = sp_q + size_word'(1);
                state_d = (w_q == '0) ? ST_DRAIN : ST_RD;
            end
            ST_RD: begin
                state_d = ST_CAP;
            end
            ST_CAP: begin
                if ({1'b0, bp_data} >= NUM_TAGS_EXT) begin
                    state_d = ST_ERR;
                    err_d   = 1'b1;
                end else begin
                    tag_d   = bp_data;
                    w_d     = w_q - size_word'(1);
                    state_d = ST_PUSH;
                end
            end
            ST_DRAIN: begin
                if (out_ready) begin
                    sp_d = sp_q - size_word'(1);
                    if (sp_q == size_word'(1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            ST_ERR: begin
                err_d   = 1'b1;
                sp_d    = '0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // The freshly pushed tag is not in the stack array yet when entering DRAIN.
        top_d       = (state_q == ST_PUSH) ? tag_q : stack_q[sp_d - size_word'(1)];
        rd_en_d     = (state_d == ST_RD);
        addr_word_d = rd_en_d ? w_d : '0;
        addr_pos_d  = rd_en_d ? tag_d : '0;
        out_valid_d = (state_d == ST_DRAIN);
        out_pos_d   = out_valid_d ? top_d : '0;
        busy_d      = (state_d != ST_IDLE);
        done_d      = (state_d == ST_DONE) || (state_d == ST_ERR);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            sp_q         <= '0;
            w_q          <= '0;
            tag_q        <= '0;
            error        <= 1'b0;
            bp_rd_en     <= 1'b0;
            bp_addr_word <= '0;
            bp_addr_pos  <= '0;
            out_valid    <= 1'b0;
            out_pos      <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            state_q      <= state_d;
            sp_q         <= sp_d;
            w_q          <= w_d;
            tag_q        <= tag_d;
            error        <= err_d;
            bp_rd_en     <= rd_en_d;
            bp_addr_word <= addr_word_d;
            bp_addr_pos  <= addr_pos_d;
            out_valid    <= out_valid_d;
            out_pos      <= out_pos_d;
            busy         <= busy_d;
            done         <= done_d;
        end
    end

    // Tag stack storage; contents are don't-care until pushed.
    always_ff @(posedge clk) begin
        if (push) begin
            stack_q[sp_q] <= tag_q;
        end
    end

endmodule

// File: tb/tb_viterbi_traceback_ctrl.sv
// Scoreboard bench for viterbi_traceback_ctrl: a reference decoder predicts tags,
// read counts and error status; a monitor checks what the DUT presents.
module tb_viterbi_traceback_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [3:0] num_words;
    logic [3:0] best_last_pos;
    logic       bp_rd_en;
    logic [3:0] bp_addr_word;
    logic [3:0] bp_addr_pos;
    logic [3:0] bp_data;
    logic [3:0] out_pos;
    logic       out_valid;
    logic       out_ready;
    logic       busy;
    logic       done;
    logic       error;
    logic [2:0] state;

    viterbi_traceback_ctrl #(.size_state(4), .size_word(4), .num_tags(12)) dut (
        .clk(clk), .reset(reset), .start(start), .num_words(num_words),
        .best_last_pos(best_last_pos), .bp_rd_en(bp_rd_en), .bp_addr_word(bp_addr_word),
        .bp_addr_pos(bp_addr_pos), .bp_data(bp_data), .out_pos(out_pos),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .done(done),
        .error(error), .state(state)
    );

    always #5 clk = ~clk;

    logic [3:0] mem [16][16];
    int exp_pos[$];
    int exp_err[$];
    int exp_rd[$];
    int n_checks = 0;
    int n_err    = 0;
    int rd_cnt   = 0;
    bit stall_prev = 0;
    bit done_prev  = 0;
    logic [3:0] held_pos;

    // Backpointer memory: one-cycle read latency, garbage when not read.
    always @(posedge clk)
        bp_data <= bp_rd_en ? mem[bp_addr_word][bp_addr_pos] : 4'($urandom_range(0, 15));

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference decoder: follows backpointers from the last word to word 0.
    task automatic model(input int n, input int best);
        int tags[16];
        int rd;
        bit err;
        rd  = 0;
        err = 0;
        if (n == 0 || best >= 12) begin
            err = 1;
        end else begin
            tags[n-1] = best;
            for (int w = n - 1; w >= 1 && !err; w--) begin
                rd++;
                if (int'(mem[w][tags[w]]) >= 12) err = 1;
                else tags[w-1] = int'(mem[w][tags[w]]);
            end
            if (!err) for (int i = 0; i < n; i++) exp_pos.push_back(tags[i]);
        end
        exp_err.push_back(int'(err));
        exp_rd.push_back(rd);
    endtask

    task automatic rand_mem(input int bad_pct);
        for (int w = 0; w < 16; w++)
            for (int t = 0; t < 16; t++)
                mem[w][t] = ($urandom_range(0, 99) < bad_pct) ? 4'($urandom_range(12, 15))
                                                               : 4'($urandom_range(0, 11));
    endtask

    // Monitor: compares DUT outputs against the scoreboard queues.
    always @(negedge clk) begin
        if (!reset) begin
            check("busy_vs_state", int'(busy), int'(state != 3'd0));
            if (bp_rd_en) rd_cnt++;
            else check("addr_idle_zero", int'({bp_addr_word, bp_addr_pos}), 0);
            if (stall_prev) begin
                check("stall_valid", int'(out_valid), 1);
                check("stall_pos", int'(out_pos), int'(held_pos));
            end
            stall_prev = out_valid && !out_ready;
            held_pos   = out_pos;
            if (out_valid && out_ready) begin
                if (exp_pos.size() == 0) check("unexpected_out", int'(out_pos), -1);
                else check("out_pos", int'(out_pos), exp_pos.pop_front());
            end
            if (done) begin
                check("done_pulse", int'(done_prev), 0);
                if (exp_err.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    check("error_flag", int'(error), exp_err.pop_front());
                    check("bp_reads", rd_cnt, exp_rd.pop_front());
                end
                rd_cnt = 0;
            end
            done_prev = done;
        end
    end

    // mode 0: ready always; 1: random ready; 2: ready pattern 1,0,0,1 while valid
    task automatic run_txn(input int n, input int best, input int mode, output int lat);
        int pat[4];
        int pidx;
        bit got_done;
        pat = '{1, 0, 0, 1};
        pidx = 0;
        lat = -1;
        model(n, best);
        start = 1'b1;
        num_words = 4'(n);
        best_last_pos = 4'(best);
        out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        got_done = done;
        for (int c = 1; c <= 400 && !got_done; c++) begin
            case (mode)
                0: out_ready = 1'b1;
                1: out_ready = 1'($urandom_range(0, 1));
                default: begin
                    out_ready = 1'(pat[pidx % 4]);
                    if (out_valid) pidx++;
                end
            endcase
            start = busy ? 1'($urandom_range(0, 1)) : 1'b0;
            num_words = 4'($urandom_range(0, 15));
            best_last_pos = 4'($urandom_range(0, 15));
            @(posedge clk); #1;
            if (out_valid && lat < 0) lat = c;
            if (done) got_done = 1;
        end
        start = 1'b0;
        if (!got_done) check("done_timeout", 0, 1);
        @(posedge clk); #1;
        check("idle_after_done", int'(state), 0);
    endtask

    task automatic set_directed_mem();
        rand_mem(0);
        mem[2][5] = 4'd7;
        mem[1][7] = 4'd2;
    endtask

    initial begin
        int lat;
        bit seen;
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        bit seen;
        reset = 1'b1;
        start = 1'b1;
        num_words = 4'd3;
        best_last_pos = 4'd5;
        out_ready = 1'b1;
        rand_mem(0);
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", int'({bp_rd_en, bp_addr_word, bp_addr_pos, out_pos, out_valid,
                                     busy, done, error, state}), 0);
        reset = 1'b0;
        start = 1'b0;
        @(posedge clk); #1;

        set_directed_mem();
        run_txn(3, 5, 0, lat);
        check("latency_n3", lat, 7);
        run_txn(1, 4, 0, lat);
        check("latency_n1", lat, 1);

        run_txn(0, 3, 0, lat);
        check("no_valid_n0", lat, -1);
        repeat (3) @(posedge clk);
        #1;
        check("error_sticky", int'(error), 1);
        run_txn(3, 12, 1, lat);
        check("no_valid_tag12", lat, -1);
        run_txn(2, 1, 1, lat);
        check("error_cleared", int'(error), 0);

        mem[2][5] = 4'd13;
        run_txn(3, 5, 0, lat);
        check("no_valid_bp13", lat, -1);
        set_directed_mem();
        run_txn(3, 5, 2, lat);
        run_txn(4, 7, 2, lat);

        // Reset after the first of three pops, with a start colliding with reset.
        model(3, 5);
        start = 1'b1;
        num_words = 4'd3;
        best_last_pos = 4'd5;
        out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        seen = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(posedge clk); #1;
            seen = out_valid;
        end
        check("reset_test_valid", int'(seen), 1);
        @(posedge clk); #1;
        reset = 1'b1;
        start = 1'b1;
        out_ready = 1'b0;
        @(posedge clk); #1;
        check("mid_drain_reset", int'({bp_rd_en, bp_addr_word, bp_addr_pos, out_pos, out_valid,
                                       busy, done, error, state}), 0);
        reset = 1'b0;
        start = 1'b0;
        exp_pos.delete();
        exp_err.delete();
        exp_rd.delete();
        rd_cnt = 0;
        stall_prev = 0;
        done_prev = 0;
        @(posedge clk); #1;
        check("no_output_after_reset", int'(out_valid), 0);
        run_txn(3, 5, 1, lat);
        check("latency_after_reset", lat, 7);

        rand_mem(0);
        run_txn(15, 11, 1, lat);
        check("latency_n15", lat, 43);

        for (int i = 0; i < 40; i++) begin
            int n;
            int best;
            rand_mem(3);
            n = $urandom_range(0, 15);
            best = ($urandom_range(0, 99) < 10) ? $urandom_range(12, 15) : $urandom_range(0, 11);
            run_txn(n, best, $urandom_range(0, 2), lat);
        end

        check("pos_queue_empty", exp_pos.size(), 0);
        check("done_queue_empty", exp_err.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
